// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-enable dual-port RAM.
// Latency: none (types and combinational helper functions only).
// Backpressure: none.
package ram_pkg;

    // Sweep-then-serve controller states.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_e;

    localparam int BYTE_W = 8;

    // One byte lane of a masked write: take the new byte when enabled.
    function automatic logic [BYTE_W-1:0] byte_merge(
        input logic [BYTE_W-1:0] old_b,
        input logic [BYTE_W-1:0] new_b,
        input logic              be_b
    );
        return be_b ? new_b : old_b;
    endfunction

    // Even-parity bit: makes the total count of ones (data + bit) even.
    function automatic logic parity8(input logic [BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read data/valid pipeline with write-first bypass select; optional RAM_PARITY_EN check.
// Latency: RD_LAT (1 or 2) cycles from request edge to o_rd_vld.
// Backpressure: none; accepts one request per cycle, output data holds between valids.
module ram_rd_pipe
    import ram_pkg::*;
#(
    parameter int DAT_W  = 32,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_req_vld,
    input  logic [DAT_W-1:0]   i_mem_dat,
    input  logic [DAT_W-1:0]   i_byp_dat,
    input  logic               i_byp_sel,
`ifdef RAM_PARITY_EN
    input  logic [DAT_W/BYTE_W-1:0] i_mem_par,
    output logic               o_perr,
`endif
    output logic               o_rd_vld,
    output logic [DAT_W-1:0]   o_dout
);

    logic [DAT_W-1:0] w_req_dat;
    logic             w_out_vld;
    logic [DAT_W-1:0] w_out_dat;
    logic             r_vld;
    logic [DAT_W-1:0] r_dout;

    assign w_req_dat = i_byp_sel ? i_byp_dat : i_mem_dat;

`ifdef RAM_PARITY_EN
    logic w_req_perr;
    logic w_out_perr;
    logic r_perr;

    // Flag any stored-byte parity mismatch; bypassed data is freshly written and never flagged.
    always_comb begin
        w_req_perr = 1'b0;
        for (int i = 0; i < DAT_W/BYTE_W; i++) begin
            if (parity8(i_mem_dat[i*BYTE_W +: BYTE_W]) != i_mem_par[i]) begin
                w_req_perr = 1'b1;
            end
        end
        if (i_byp_sel) begin
            w_req_perr = 1'b0;
        end
    end
`endif

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic             r_s1_vld;
            logic [DAT_W-1:0] r_s1_dat;
`ifdef RAM_PARITY_EN
            logic             r_s1_perr;
`endif

            // First register stage; the output stage below adds the second cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s1_vld  <= 1'b0;
                    r_s1_dat  <= '0;
`ifdef RAM_PARITY_EN
                    r_s1_perr <= 1'b0;
`endif
                end else begin
                    r_s1_vld <= i_req_vld;
                    if (i_req_vld) begin
                        r_s1_dat  <= w_req_dat;
`ifdef RAM_PARITY_EN
                        r_s1_perr <= w_req_perr;
`endif
                    end
                end
            end

            assign w_out_vld  = r_s1_vld;
            assign w_out_dat  = r_s1_dat;
`ifdef RAM_PARITY_EN
            assign w_out_perr = r_s1_perr;
`endif
        end else begin : g_lat1
            assign w_out_vld  = i_req_vld;
            assign w_out_dat  = w_req_dat;
`ifdef RAM_PARITY_EN
            assign w_out_perr = w_req_perr;
`endif
        end
    endgenerate

    // Output stage: valid is a one-cycle pulse, data only updates on a valid and otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= 1'b0;
            r_dout <= '0;
`ifdef RAM_PARITY_EN
            r_perr <= 1'b0;
`endif
        end else begin
            r_vld <= w_out_vld;
            if (w_out_vld) begin
                r_dout <= w_out_dat;
            end
`ifdef RAM_PARITY_EN
            r_perr <= w_out_vld & w_out_perr;
`endif
        end
    end

    assign o_rd_vld = r_vld;
    assign o_dout   = r_dout;
`ifdef RAM_PARITY_EN
    assign o_perr   = r_perr;
`endif

endmodule

// File: rtl/ram_dp_be.sv
// Simple dual-port RAM with byte enables, write-first bypass and post-reset clear sweep; optional RAM_PARITY_EN.
// Latency: read data and rd_valid RD_LAT cycles after the request edge; clear sweep is MEM_DEPTH cycles.
// Backpressure: none; while busy=1 all requests are dropped, otherwise 1 write + 1 read per cycle.
module ram_dp_be
    import ram_pkg::*;
#(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = $clog2(MEM_DEPTH),
    parameter int RD_LAT    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [ADDR_SIZE-1:0]        addr_wr,
    input  logic [MEM_WIDTH-1:0]        din,
    input  logic [MEM_WIDTH/BYTE_W-1:0] be,
    input  logic                        rd_en,
    input  logic [ADDR_SIZE-1:0]        addr_rd,
    output logic [MEM_WIDTH-1:0]        dout,
    output logic                        rd_valid,
`ifdef RAM_PARITY_EN
    output logic                        par_err,
`endif
    output logic                        busy
);

    localparam int                   NB        = MEM_WIDTH / BYTE_W;
    // One extra bit so the range check is meaningful even for power-of-two depths.
    localparam logic [ADDR_SIZE:0]   DEPTH_X   = (ADDR_SIZE+1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    logic [MEM_WIDTH-1:0] r_mem [MEM_DEPTH];
`ifdef RAM_PARITY_EN
    logic [NB-1:0]        r_par [MEM_DEPTH];
    logic [NB-1:0]        w_rd_par;
`endif

    ram_state_e           r_state;
    logic [ADDR_SIZE-1:0] r_clr_cnt;
    logic                 r_busy;

    logic                 w_ready;
    logic                 w_clr_we;
    logic                 w_wr_in_rng;
    logic                 w_rd_in_rng;
    logic                 w_wr_go;
    logic                 w_rd_go;
    logic                 w_collide;
    logic [MEM_WIDTH-1:0] w_rd_old;
    logic [MEM_WIDTH-1:0] w_byp_dat;

    // Requests are only honoured once the sweep has finished and reset is low.
    assign w_ready     = (r_state == READY) && !rst;
    assign w_clr_we    = (r_state == CLEAR) && !rst;
    assign w_wr_in_rng = {1'b0, addr_wr} < DEPTH_X;
    assign w_rd_in_rng = {1'b0, addr_rd} < DEPTH_X;
    // Out-of-range writes vanish; out-of-range reads still return a valid (zero) word.
    assign w_wr_go     = w_ready && wr_en && w_wr_in_rng;
    assign w_rd_go     = w_ready && rd_en;
    assign w_collide   = w_wr_go && (addr_wr == addr_rd);
    assign w_rd_old    = w_rd_in_rng ? r_mem[addr_rd] : '0;
`ifdef RAM_PARITY_EN
    assign w_rd_par    = w_rd_in_rng ? r_par[addr_rd] : '0;
`endif

    // Write-first view of a colliding word: enabled bytes from din, the rest from the array.
    always_comb begin
        w_byp_dat = '0;
        for (int i = 0; i < NB; i++) begin
            w_byp_dat[i*BYTE_W +: BYTE_W] = byte_merge(w_rd_old[i*BYTE_W +: BYTE_W],
                                                       din[i*BYTE_W +: BYTE_W], be[i]);
        end
    end

    // Controller: sweep every word to zero after reset, then serve requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                CLEAR: begin
                    if (r_clr_cnt == LAST_ADDR) begin
                        r_state   <= READY;
                        r_busy    <= 1'b0;
                        r_clr_cnt <= '0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                READY: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_state <= CLEAR;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    // Array write port: clear sweep has the port exclusively, else per-byte masked writes.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_cnt] <= '0;
`ifdef RAM_PARITY_EN
            r_par[r_clr_cnt] <= '0;
`endif
        end else if (w_wr_go) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    r_mem[addr_wr][i*BYTE_W +: BYTE_W] <= din[i*BYTE_W +: BYTE_W];
`ifdef RAM_PARITY_EN
                    r_par[addr_wr][i] <= parity8(din[i*BYTE_W +: BYTE_W]);
`endif
                end
            end
        end
    end

    ram_rd_pipe #(
        .DAT_W  (MEM_WIDTH),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .i_req_vld (w_rd_go),
        .i_mem_dat (w_rd_old),
        .i_byp_dat (w_byp_dat),
        .i_byp_sel (w_collide),
`ifdef RAM_PARITY_EN
        .i_mem_par (w_rd_par),
        .o_perr    (par_err),
`endif
        .o_rd_vld  (rd_valid),
        .o_dout    (dout)
    );

    assign busy = r_busy;

endmodule

// File: tb/tb_ram_dp_be.sv
// Directed bench for ram_dp_be: three instances (lat1/256, lat2/256, lat1/200) share one stimulus.
// A schedule-based word model predicts busy, rd_valid and dout every cycle; pinned literals anchor it.
// Inputs change on the falling edge, outputs are sampled 1 time unit after the rising edge.
module tb_ram_dp_be;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  addr_wr = '0;
    logic [7:0]  addr_rd = '0;
    logic [31:0] din = '0;
    logic [3:0]  be = '0;

    logic [31:0] dout_a [3];
    logic        rv_a   [3];
    logic        busy_a [3];
`ifdef RAM_PARITY_EN
    logic        perr_a [3];
`endif

    always #5 clk = ~clk;

    ram_dp_be #(.MEM_WIDTH(32), .MEM_DEPTH(256), .RD_LAT(1)) u_dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .addr_wr(addr_wr), .din(din), .be(be),
        .rd_en(rd_en), .addr_rd(addr_rd), .dout(dout_a[0]), .rd_valid(rv_a[0]),
`ifdef RAM_PARITY_EN
        .par_err(perr_a[0]),
`endif
        .busy(busy_a[0]));

    ram_dp_be #(.MEM_WIDTH(32), .MEM_DEPTH(256), .RD_LAT(2)) u_dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .addr_wr(addr_wr), .din(din), .be(be),
        .rd_en(rd_en), .addr_rd(addr_rd), .dout(dout_a[1]), .rd_valid(rv_a[1]),
`ifdef RAM_PARITY_EN
        .par_err(perr_a[1]),
`endif
        .busy(busy_a[1]));

    ram_dp_be #(.MEM_WIDTH(32), .MEM_DEPTH(200), .RD_LAT(1)) u_dut2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .addr_wr(addr_wr), .din(din), .be(be),
        .rd_en(rd_en), .addr_rd(addr_rd), .dout(dout_a[2]), .rd_valid(rv_a[2]),
`ifdef RAM_PARITY_EN
        .par_err(perr_a[2]),
`endif
        .busy(busy_a[2]));

    function automatic int dep(input int i);
        return (i == 2) ? 200 : 256;
    endfunction

    function automatic int lat(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    typedef struct packed {
        logic        vld;
        logic [31:0] dat;
        logic        perr;
        logic        pin_on;
        logic [31:0] pin;
    } exp_t;

    logic [31:0] mm      [3][256];
    logic [3:0]  corrupt [3][256];
    exp_t        sched   [3][4];
    int          clr_left [3];
    logic [31:0] exp_dout [3];
    int          edge_n = 0;
    bit          armed  = 1'b0;
    int          n_cmp  = 0;
    int          n_bad  = 0;

    bit          pin_on = 1'b0;
    logic [31:0] pin_v  = '0;
    logic [31:0] pin2_v = '0;

    exp_t        e_tmp;
    bit          wok, rok, col;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model update at each rising edge, then compare every instance just after the edge.
    always @(posedge clk) begin
        edge_n++;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                clr_left[i] = dep(i);
                exp_dout[i] = '0;
                for (int a = 0; a < 256; a++) begin
                    mm[i][a]      = '0;
                    corrupt[i][a] = '0;
                end
                for (int s = 0; s < 4; s++) sched[i][s] = '0;
            end else if (clr_left[i] > 0) begin
                clr_left[i]--;
            end else begin
                wok = int'(addr_wr) < dep(i);
                rok = int'(addr_rd) < dep(i);
                col = wr_en && wok && (addr_wr == addr_rd);
                if (wr_en && wok) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) begin
                            mm[i][addr_wr][b*8 +: 8] = din[b*8 +: 8];
                            corrupt[i][addr_wr][b]   = 1'b0;
                        end
                    end
                end
                if (rd_en) begin
                    e_tmp.vld    = 1'b1;
                    e_tmp.dat    = rok ? mm[i][addr_rd] : 32'h0;
                    e_tmp.perr   = rok && !col && (corrupt[i][addr_rd] != 4'h0);
                    e_tmp.pin_on = pin_on;
                    e_tmp.pin    = (i == 2) ? pin2_v : pin_v;
                    sched[i][(edge_n + lat(i) - 1) % 4] = e_tmp;
                end
            end
        end
        if (rst) armed = 1'b1;
        #1;
        if (armed) begin
            for (int i = 0; i < 3; i++) begin
                e_tmp = sched[i][edge_n % 4];
                chk($sformatf("busy%0d", i), 32'(busy_a[i]), 32'(clr_left[i] > 0));
                chk($sformatf("rd_valid%0d", i), 32'(rv_a[i]), 32'(e_tmp.vld));
                if (e_tmp.vld) begin
                    exp_dout[i] = e_tmp.dat;
                    if (e_tmp.pin_on) chk($sformatf("pinned_dout%0d", i), dout_a[i], e_tmp.pin);
                    sched[i][edge_n % 4].vld = 1'b0;
                end
                chk($sformatf("dout%0d", i), dout_a[i], exp_dout[i]);
`ifdef RAM_PARITY_EN
                chk($sformatf("par_err%0d", i), 32'(perr_a[i]), 32'(e_tmp.vld && e_tmp.perr));
`endif
            end
        end
    end

    task automatic step(input bit we, input logic [7:0] aw, input logic [31:0] d, input logic [3:0] b,
                        input bit re, input logic [7:0] ar, input bit pe,
                        input logic [31:0] pv, input logic [31:0] pv2);
        @(negedge clk);
        wr_en = we; addr_wr = aw; din = d; be = b;
        rd_en = re; addr_rd = ar;
        pin_on = pe; pin_v = pv; pin2_v = pv2;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
        step(1'b1, a, d, b, 1'b0, 8'h00, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] pv, input logic [31:0] pv2);
        step(1'b0, 8'h00, 32'h0, 4'h0, 1'b1, a, 1'b1, pv, pv2);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 8'h00, 1'b0, 32'h0, 32'h0);
    endtask

    // Release reset and measure how long busy stays high on the 256- and 200-deep instances.
    task automatic release_and_count(input bit poke);
        int c0;
        int c2;
        c0 = 0;
        c2 = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (busy_a[0]) c0++;
            if (busy_a[2]) c2++;
            if (!busy_a[0] && !busy_a[2]) break;
            if (poke && (k == 5 || k == 100 || k == 255)) begin
                wr_en = 1'b1; addr_wr = 8'h10; din = 32'hFFFF_FFFF; be = 4'hF;
                rd_en = 1'b1; addr_rd = 8'h10;
            end else begin
                wr_en = 1'b0; rd_en = 1'b0;
            end
            @(negedge clk);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("busy_len_256", 32'(c0), 32'd256);
        chk("busy_len_200", 32'(c2), 32'd200);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        release_and_count(1'b1);

        // Cleared word; the 200-deep instance already served the last poke (write-first).
        rd(8'h10, 32'h0000_0000, 32'hFFFF_FFFF);

        // Byte-masked overwrite.
        wr(8'h00, 32'hDEAD_BEEF, 4'b1111);
        wr(8'h00, 32'h1122_3344, 4'b0101);
        rd(8'h00, 32'hDE22_BE44, 32'hDE22_BE44);

        // Same-cycle collisions at 0xFF (out of range on the 200-deep instance).
        step(1'b1, 8'hFF, 32'hA5A5_A5A5, 4'b1111, 1'b1, 8'hFF, 1'b1, 32'hA5A5_A5A5, 32'h0);
        wr(8'hFF, 32'h1234_5678, 4'b1111);
        step(1'b1, 8'hFF, 32'hA5A5_A5A5, 4'b0011, 1'b1, 8'hFF, 1'b1, 32'h1234_A5A5, 32'h0);

        // Streaming reads, contents equal address.
        for (int a = 0; a < 8; a++) wr(8'(a), 32'(a), 4'hF);
        for (int a = 0; a < 8; a++) rd(8'(a), 32'(a), 32'(a));

        // Different addresses in the same cycle are independent.
        step(1'b1, 8'h20, 32'hCAFE_F00D, 4'hF, 1'b1, 8'h21, 1'b1, 32'h0, 32'h0);
        rd(8'h20, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // be=0 is a no-op.
        wr(8'h01, 32'hFFFF_FFFF, 4'h0);
        rd(8'h01, 32'h0000_0001, 32'h0000_0001);

        // Depth boundary on the 200-deep instance.
        wr(8'hC7, 32'h7777_7777, 4'hF);
        wr(8'hC8, 32'h8888_8888, 4'hF);
        rd(8'hC7, 32'h7777_7777, 32'h7777_7777);
        rd(8'hC8, 32'h8888_8888, 32'h0);
        idle(4);

`ifdef RAM_PARITY_EN
        @(negedge clk);
        u_dut0.r_par[5][0] = ~u_dut0.r_par[5][0];
        corrupt[0][5][0]   = 1'b1;
        rd(8'h05, 32'h5, 32'h5);
        @(posedge clk);
        #2;
        chk("par_err_injected", 32'(perr_a[0]), 32'd1);
        rd(8'h06, 32'h6, 32'h6);
        idle(4);
`endif

        // Reset at sweep count 100 restarts the full sweep and wipes earlier data.
        wr(8'h80, 32'h5A5A_5A5A, 4'hF);
        idle(1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        release_and_count(1'b0);
        rd(8'h80, 32'h0, 32'h0);
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
